// File: rtl/instruction_memory_loader_if.sv
// Load/fetch bus of the instruction memory loader.
// The master drives mode, load beats and fetch requests; the slave answers.
interface instruction_memory_loader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
);
  logic              init_mode;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic [ADDR_W:0]   load_count;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ready;
  logic              instr_valid;
  logic [DATA_W-1:0] instruction;
  logic              fault;
  logic [1:0]        fault_code;

  modport master (
    output init_mode, load_valid, load_data, fetch_req, fetch_addr,
    input  load_ready, load_count, fetch_ready, instr_valid, instruction,
           fault, fault_code
  );

  modport slave (
    input  init_mode, load_valid, load_data, fetch_req, fetch_addr,
    output load_ready, load_count, fetch_ready, instr_valid, instruction,
           fault, fault_code
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Instruction memory with a streaming load phase and a pipelined fetch phase.
// Fetches are classified (misaligned / out of range / unloaded) one cycle after acceptance.
module instruction_memory_loader #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 4096,
  parameter int unsigned       ADDR_W    = $clog2(DEPTH),
  parameter logic [31:0]       BASE_ADDR = 32'h0040_0000,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  instruction_memory_loader_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                load_ready_q;
  logic                fetch_ready_q;
  logic                instr_valid_q;
  logic [DATA_W-1:0]   instr_q;
  logic                fault_q;
  logic [1:0]          fault_code_q;

  // Contents are never reset; the load count alone decides what is visible.
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                load_fire;
  logic                fetch_fire;
  logic [31:0]         offset;
  logic [31:0]         word_idx;
  logic [ADDR_W-1:0]   rd_idx;
  logic [1:0]          code;

  assign load_fire  = bus.load_valid && load_ready_q;
  assign fetch_fire = bus.fetch_req && fetch_ready_q;

  assign offset   = bus.fetch_addr - BASE_ADDR;
  assign word_idx = offset >> 2;
  assign rd_idx   = word_idx[ADDR_W-1:0];

  always_comb begin
    code = 2'b00;
    if (bus.fetch_addr[1:0] != 2'b00)
      code = 2'b01;
    else if ((bus.fetch_addr < BASE_ADDR) || (word_idx >= 32'(DEPTH)))
      code = 2'b10;
    else if (word_idx >= 32'(cnt_q))
      code = 2'b11;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load_fire)
      cnt_d = cnt_q + (ADDR_W+1)'(1);
    case (state_q)
      IDLE: if (bus.init_mode) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: if (!bus.init_mode) state_d = RUN;
      RUN: if (bus.init_mode) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Readies are registered from next-state values so they match the state they gate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      load_ready_q  <= 1'b0;
      fetch_ready_q <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_WORD;
      fault_q       <= 1'b0;
      fault_code_q  <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      load_ready_q  <= (state_d == LOAD) && (cnt_d < DEPTH_C);
      fetch_ready_q <= (state_d == RUN);
      instr_valid_q <= fetch_fire;
      if (fetch_fire && (code == 2'b00)) begin
        instr_q      <= mem[rd_idx];
        fault_q      <= 1'b0;
        fault_code_q <= 2'b00;
      end else if (fetch_fire) begin
        instr_q      <= NOP_WORD;
        fault_q      <= 1'b1;
        fault_code_q <= code;
      end else begin
        instr_q      <= NOP_WORD;
        fault_q      <= 1'b0;
        fault_code_q <= 2'b00;
      end
    end
  end

  // load_fire already implies cnt_q < DEPTH, so the low bits are a valid index.
  always_ff @(posedge clk) begin
    if (rst_n && load_fire)
      mem[cnt_q[ADDR_W-1:0]] <= bus.load_data;
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.load_count  = cnt_q;
  assign bus.fetch_ready = fetch_ready_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instruction = instr_q;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = fault_code_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Bench: two loaders (DEPTH 4096 and 4) share one stimulus stream; a behavioural
// model predicts every output each cycle, with literal pins on known scenarios.
module tb_instruction_memory_loader;
  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int DEP [2] = '{4096, 4};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_mode, load_valid, fetch_req;
  logic [31:0] load_data, fetch_addr;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  instruction_memory_loader_if #(.DATA_W(32), .ADDR_W(12)) ifa ();
  instruction_memory_loader_if #(.DATA_W(32), .ADDR_W(2))  ifb ();

  assign ifa.init_mode  = init_mode;
  assign ifa.load_valid = load_valid;
  assign ifa.load_data  = load_data;
  assign ifa.fetch_req  = fetch_req;
  assign ifa.fetch_addr = fetch_addr;
  assign ifb.init_mode  = init_mode;
  assign ifb.load_valid = load_valid;
  assign ifb.load_data  = load_data;
  assign ifb.fetch_req  = fetch_req;
  assign ifb.fetch_addr = fetch_addr;

  instruction_memory_loader u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  instruction_memory_loader #(.DEPTH(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  // Model: mode 0 idle, 1 loading, 2 running.
  int          m_mode [2];
  int          m_cnt  [2];
  bit          m_v    [2];
  logic [31:0] m_ins  [2];
  int          m_code [2];
  logic [31:0] m_mem  [2][4096];
  bit          m_lr, m_fr;

  function automatic int classify(logic [31:0] a, int dep, int cnt);
    longint idx;
    if (a % 4 != 0) return 1;
    if (a < BASE) return 2;
    idx = longint'(a - BASE) / 4;
    if (idx >= dep) return 2;
    if (idx >= cnt) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_mode[d] = 0; m_cnt[d] = 0; m_v[d] = 0; m_ins[d] = 0; m_code[d] = 0;
        armed = 1'b1;
      end else begin
        m_lr = (m_mode[d] == 1) && (m_cnt[d] < DEP[d]);
        m_fr = (m_mode[d] == 2);
        m_v[d] = fetch_req && m_fr;
        m_code[d] = 0;
        m_ins[d] = 0;
        if (m_v[d]) begin
          m_code[d] = classify(fetch_addr, DEP[d], m_cnt[d]);
          if (m_code[d] == 0) m_ins[d] = m_mem[d][(fetch_addr - BASE) / 4];
        end
        if (load_valid && m_lr) begin
          m_mem[d][m_cnt[d]] = load_data;
          m_cnt[d]++;
        end
        case (m_mode[d])
          0: if (init_mode) begin m_mode[d] = 1; m_cnt[d] = 0; end
          1: if (!init_mode) m_mode[d] = 2;
          default: if (init_mode) begin m_mode[d] = 1; m_cnt[d] = 0; end
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int d, input logic lr, input logic fr, input logic [63:0] lc,
                     input logic iv, input logic [31:0] ins, input logic f, input logic [1:0] fc);
    string p;
    p = $sformatf("dut%0d ", d);
    chk({p, "load_ready"},  64'(lr),  64'((m_mode[d] == 1) && (m_cnt[d] < DEP[d])));
    chk({p, "fetch_ready"}, 64'(fr),  64'(m_mode[d] == 2));
    chk({p, "load_count"},  lc,       64'(m_cnt[d]));
    chk({p, "instr_valid"}, 64'(iv),  64'(m_v[d]));
    chk({p, "instruction"}, 64'(ins), 64'(m_ins[d]));
    chk({p, "fault"},       64'(f),   64'(m_code[d] != 0));
    chk({p, "fault_code"},  64'(fc),  64'(m_code[d]));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp(0, ifa.load_ready, ifa.fetch_ready, 64'(ifa.load_count), ifa.instr_valid,
          ifa.instruction, ifa.fault, ifa.fault_code);
      cmp(1, ifb.load_ready, ifb.fetch_ready, 64'(ifb.load_count), ifb.instr_valid,
          ifb.instruction, ifb.fault, ifb.fault_code);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic beat(input logic [31:0] dat);
    load_valid = 1'b1;
    load_data  = dat;
    step();
    load_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req  = 1'b0;
    sample();
  endtask

  logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    rst_n = 1'b0; init_mode = 1'b0; load_valid = 1'b0; fetch_req = 1'b0;
    load_data = '0; fetch_addr = '0;
    step(); step();
    sample();
    chk("rst load_ready",  64'(ifa.load_ready),  64'd0);
    chk("rst fetch_ready", 64'(ifa.fetch_ready), 64'd0);
    chk("rst instr_valid", 64'(ifa.instr_valid), 64'd0);
    chk("rst instruction", 64'(ifa.instruction), 64'd0);
    chk("rst fault_code",  64'(ifa.fault_code),  64'd0);
    chk("rst load_count",  64'(ifa.load_count),  64'd0);

    rst_n = 1'b1; init_mode = 1'b1;
    step();
    for (int i = 0; i < 4; i++) beat(vals[i]);
    sample();
    chk("load4 count",          64'(ifa.load_count), 64'd4);
    chk("depth4 full ready",    64'(ifb.load_ready), 64'd0);
    chk("depth4096 ready",      64'(ifa.load_ready), 64'd1);
    init_mode = 1'b0;
    step();

    fetch(32'h0040_0008);
    chk("fetch idx2 valid", 64'(ifa.instr_valid), 64'd1);
    chk("fetch idx2 data",  64'(ifa.instruction), 64'h33);
    chk("fetch idx2 code",  64'(ifa.fault_code),  64'd0);
    fetch(32'h0040_0010);
    chk("unloaded code",    64'(ifa.fault_code),  64'd3);
    chk("unloaded nop",     64'(ifa.instruction), 64'd0);
    chk("unloaded fault",   64'(ifa.fault),       64'd1);
    chk("depth4 oor code",  64'(ifb.fault_code),  64'd2);
    fetch(32'h0040_0006);
    chk("misaligned code",  64'(ifa.fault_code),  64'd1);
    fetch(32'h003F_FFFC);
    chk("below base code",  64'(ifa.fault_code),  64'd2);

    fetch_req = 1'b1; fetch_addr = 32'h0040_0000;
    step(); fetch_addr = 32'h0040_0004;
    sample(); chk("b2b 0", 64'(ifa.instruction), 64'h11);
    step(); fetch_addr = 32'h0040_0008;
    sample(); chk("b2b 1", 64'(ifa.instruction), 64'h22);
    step(); fetch_req = 1'b0;
    sample(); chk("b2b 2", 64'(ifa.instruction), 64'h33);
    step();
    sample(); chk("b2b idle", 64'(ifa.instr_valid), 64'd0);

    init_mode = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0040_0004;
    step();
    sample();
    chk("switch edge valid", 64'(ifa.instr_valid), 64'd1);
    chk("switch edge data",  64'(ifa.instruction), 64'h22);
    chk("switch fetch_rdy",  64'(ifa.fetch_ready), 64'd0);
    chk("switch count",      64'(ifa.load_count),  64'd0);
    step();
    sample();
    chk("fetch in load", 64'(ifa.instr_valid), 64'd0);
    fetch_req = 1'b0;

    for (int i = 0; i < 6; i++) beat(32'hA0 + 32'(i));
    sample();
    chk("overflow count d4",  64'(ifb.load_count), 64'd4);
    chk("overflow ready d4",  64'(ifb.load_ready), 64'd0);
    chk("overflow count big", 64'(ifa.load_count), 64'd6);
    init_mode = 1'b0;
    step();
    fetch(32'h0040_0010);
    chk("d4 idx4 code",  64'(ifb.fault_code),  64'd2);
    chk("big idx4 data", 64'(ifa.instruction), 64'hA4);

    init_mode = 1'b1;
    step();
    beat(32'hB0); beat(32'hB1);
    rst_n = 1'b0; load_valid = 1'b1; load_data = 32'hEE;
    step();
    rst_n = 1'b1; load_valid = 1'b0;
    sample();
    chk("reset mid-load count", 64'(ifa.load_count), 64'd0);
    step();
    beat(32'hAA);
    init_mode = 1'b0;
    step();
    fetch(32'h0040_0000);
    chk("reload idx0", 64'(ifa.instruction), 64'hAA);
    fetch(32'h0040_0004);
    chk("reload idx1 code", 64'(ifa.fault_code), 64'd3);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) init_mode = ~init_mode;
      rst_n      = ($urandom_range(0, 299) != 0);
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = $urandom;
      fetch_req  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: fetch_addr = $urandom;
        1: fetch_addr = BASE + 32'($urandom_range(0, 20) * 4 + $urandom_range(1, 3));
        2: fetch_addr = BASE - 32'(4 * $urandom_range(1, 4));
        3: fetch_addr = BASE + 32'(4 * (4096 - $urandom_range(0, 3)));
        default: fetch_addr = BASE + 32'(4 * $urandom_range(0, 12));
      endcase
      step();
    end
    fetch_req = 1'b0; load_valid = 1'b0;
    step();
    sample();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_memory_loader.md
INSTRUCTION_MEMORY_LOADER -- requirements
Module: instruction_memory_loader

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 32, instruction word width.
- DEPTH, default 4096, number of words; power of two, at least 2.
- ADDR_W, default $clog2(DEPTH), word index width.
- BASE_ADDR, default 32'h0040_0000, byte address of word 0.
- NOP_WORD, default 0, value returned on any faulted fetch.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst_n, in, 1, synchronous active-low reset.
- init_mode, in, 1, 1 = load phase, 0 = run phase.
- load_valid, in, 1, load beat offered.
- load_data, in, DATA_W, load beat payload.
- load_ready, out, 1, load beat acceptable.
- load_count, out, ADDR_W+1, words loaded since the last load start.
- fetch_req, in, 1, fetch request.
- fetch_addr, in, 32, byte address of the fetch.
- fetch_ready, out, 1, fetch request acceptable.
- instr_valid, out, 1, fetch response strobe.
- instruction, out, DATA_W, fetch response data.
- fault, out, 1, response is faulted.
- fault_code, out, 2, fault cause: 00 none, 01 misaligned, 10 out of range, 11 unloaded.
REQ-003 The block SHALL have one clock, clk; reset SHALL be rst_n, synchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, LOAD and RUN.
REQ-005 IDLE: init_mode=1 -> LOAD, with load_count cleared to 0 on the transition edge.
REQ-006 LOAD: init_mode=0 -> RUN.
REQ-007 RUN: init_mode=1 -> LOAD, with load_count cleared to 0.
REQ-008 load_ready SHALL be 1 only in LOAD with load_count < DEPTH.
REQ-009 A beat SHALL be accepted when load_valid && load_ready: mem[load_count] <= load_data, and load_count increments.
REQ-010 When load_count == DEPTH, load_ready SHALL be 0 and further beats SHALL be ignored without wrapping.
REQ-011 fetch_ready SHALL be 1 only in RUN.
REQ-012 fetch_req while fetch_ready=0 SHALL be ignored and produce no response.
REQ-013 An accepted fetch (fetch_req && fetch_ready) SHALL produce exactly one response on the next cycle: instr_valid=1 for one cycle.
REQ-014 Fetches SHALL be pipelined: back-to-back accepts yield back-to-back responses, one per cycle, in order.
REQ-015 offset = fetch_addr - BASE_ADDR, computed 32-bit unsigned; index = offset >> 2.
REQ-016 Fault classification SHALL use fixed priority, first match wins:
- fetch_addr[1:0] != 0 -> 01 (misaligned).
- fetch_addr < BASE_ADDR, or index >= DEPTH -> 10 (out of range).
- index >= load_count -> 11 (unloaded).
- otherwise -> 00.
REQ-017 Faulted response: instruction=NOP_WORD, fault=1. Clean response: instruction=mem[index], fault=0.
REQ-018 When instr_valid=0, instruction SHALL be NOP_WORD, fault=0 and fault_code=00.
REQ-019 A fetch accepted on the same edge as the RUN->LOAD transition SHALL still produce its response on the next cycle; subsequent fetches are blocked.
REQ-020 Memory contents SHALL persist across reset and reloads; only the load_count bound gates visibility.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force:
- state = IDLE, load_count = 0.
- load_ready = 0, fetch_ready = 0, instr_valid = 0.
- instruction = NOP_WORD, fault = 0, fault_code = 00.
REQ-022 Reset during LOAD SHALL abort the load: the next load restarts at index 0, and no write occurs on the reset edge.
REQ-023 Reset SHALL discard any in-flight fetch response.

Verification
REQ-024 Load 4 words 0x11, 0x22, 0x33, 0x44, drop init_mode, fetch 0x0040_0008 -> next cycle instr_valid=1, instruction=0x33, fault_code=00; load_count=4.
REQ-025 After the 4-word load, fetch 0x0040_0010 -> NOP_WORD, fault_code=11; fetch 0x0040_0006 -> fault_code=01; fetch 0x003F_FFFC -> fault_code=10.
REQ-026 DEPTH=4, present 6 beats -> exactly 4 accepted, load_ready=0 from count 4; fetch 0x0040_0010 -> fault_code=10.
REQ-027 Fetches at 0x0040_0000, 0x0040_0004, 0x0040_0008 on consecutive cycles -> 3 consecutive responses 0x11, 0x22, 0x33.
REQ-028 Assert rst_n=0 after 2 load beats, reload 1 beat 0xAA, fetch index 0 -> 0xAA; fetch index 1 -> fault_code=11.
REQ-029 Fetch while in LOAD or IDLE -> fetch_ready=0 and no instr_valid pulse.
